// File: rtl/sram_read_responder.sv
// rtl/sram_read_responder.sv - single-outstanding read responder over a word-addressed SRAM
//
// Ports:
//   clk, rst           clock (rising edge) and asynchronous active-low reset
//   arvalid/arready    read address handshake, araddr is a byte address
//   rvalid/rready      read data handshake carrying rdata and rresp
//   rresp              00 OKAY, 10 SLVERR (misaligned), 11 DECERR (out of range)
//   ld_en/ld_addr/ld_data  preload write port, usable in any state
module sram_read_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          FIXED_LAT  = 1,
    parameter int          RAND_EN    = 0,
    parameter logic [7:0]  SEED       = 8'd211
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arvalid,
    input  logic [31:0]           araddr,
    output logic                  arready,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] FIXED_LOAD = 4'(FIXED_LAT - 1);

    state_t      state;
    logic [31:0] addr_q;
    logic [3:0]  cnt;
    logic [7:0]  lfsr;
    logic        lfsr_fb;

    logic [31:0] mem [2**DEPTH_LOG2];

    // Word offset from the base; addresses below the base wrap to large
    // values and therefore land in the out-of-range check.
    logic [29:0] off_word;
    logic        misaligned;
    logic        out_of_range;

    assign off_word     = addr_q[31:2] - BASE_ADDR[31:2];
    assign misaligned   = (addr_q[1:0] != 2'b00);
    assign out_of_range = (off_word[29:DEPTH_LOG2] != '0);

    // Fibonacci LFSR, taps 8,6,5,4
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // Memory is not reset; a write colliding with the WAIT->RESP read
    // returns the old word because both use the same edge.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= 32'h0;
            rresp   <= 2'b00;
            addr_q  <= 32'h0;
            cnt     <= 4'h0;
            lfsr    <= SEED;
        end else begin
            case (state)
                IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        addr_q  <= araddr;
                        arready <= 1'b0;
                        cnt     <= (RAND_EN != 0) ? lfsr[3:0] : FIXED_LOAD;
                        lfsr    <= {lfsr[6:0], lfsr_fb};
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'h0) begin
                        rvalid <= 1'b1;
                        state  <= RESP;
                        if (misaligned) begin
                            rresp <= 2'b10;
                            rdata <= 32'h0;
                        end else if (out_of_range) begin
                            rresp <= 2'b11;
                            rdata <= 32'h0;
                        end else begin
                            rresp <= 2'b00;
                            rdata <= mem[off_word[DEPTH_LOG2-1:0]];
                        end
                    end else begin
                        cnt <= cnt - 4'h1;
                    end
                end
                RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    arready <= 1'b0;
                    rvalid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_read_responder.md
Name: sram_read_responder

Overview:
- Responder (slave) end of the instruction-fetch read channel; serves fetch requests from the IFU.
- Accepts one read address on AR, waits a programmable or pseudo-random number of cycles, then returns one 32-bit word plus response on R.
- Backed by a word-addressed synchronous memory array, with a side write port for preload from the bench or loader.
- Sits between the IFU and the memory model; the LFSR delay stresses IFU handshake robustness.

Parameters:
- DEPTH_LOG2, 10, log2 of word count (1024 words).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- FIXED_LAT, 1, cycles from AR accept to rvalid when RAND_EN=0 (1..15).
- RAND_EN, 0, 1 = delay taken from LFSR instead of FIXED_LAT.
- SEED, 8'd211, LFSR reset value (must be nonzero).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- arvalid  in  1  read address valid.
- araddr  in  32  byte read address.
- arready  out  1  address accepted when arvalid&arready.
- rvalid  out  1  read data valid.
- rready  in  1  requester accepts data.
- rdata  out  32  read word.
- rresp  out  2  00 OKAY, 10 SLVERR (misaligned), 11 DECERR (out of range).
- ld_en  in  1  preload write enable.
- ld_addr  in  DEPTH_LOG2  preload word index.
- ld_data  in  32  preload word.

Behaviour:
- Reset (rst=0, asynchronous) forces: state=IDLE, arready=0, rvalid=0, rdata=0, rresp=00, delay counter=0, LFSR=SEED. Memory contents are not reset.
- arready, rvalid, rdata and rresp are all registered.
- States: IDLE, WAIT, RESP. Only one transaction is outstanding at a time.
- IDLE:
  - arready=1 from the first clock edge after rst releases.
  - On arvalid&arready: latch araddr, drop arready next cycle, load the counter, go to WAIT.
  - Counter load value: RAND_EN=0 → FIXED_LAT-1; RAND_EN=1 → LFSR[3:0]. A value of 0 gives the minimum latency.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Steps once per accepted AR only.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter is 0: read the array, compute rresp, set rvalid=1 next cycle, go to RESP.
  - Minimum accept-to-rvalid latency is 1 cycle.
- Address decode, with off = araddr - BASE_ADDR:
  - araddr[1:0]≠0 → SLVERR, rdata=0.
  - off ≥ 4·2^DEPTH_LOG2 (unsigned; addresses below BASE wrap large) → DECERR, rdata=0.
  - Otherwise OKAY, rdata = mem[off[DEPTH_LOG2+1:2]].
  - Misalignment is checked first.
- RESP:
  - rvalid, rdata and rresp hold stable until rvalid&rready.
  - On that handshake cycle: next cycle rvalid=0, arready=1, state IDLE.
  - rready held high before rvalid is legal and causes nothing until rvalid rises.
  - Back-to-back: the earliest next AR accept is the cycle after the R handshake.
- arvalid while not in IDLE is ignored (arready=0). The requester must hold arvalid and araddr until accepted.
- Preload:
  - ld_en writes mem[ld_addr] on the clock edge.
  - If ld_en targets the word being read in the same cycle as the WAIT→RESP read, the read returns the old data.
  - Preload is allowed in any state.
- Reset mid-transaction: the transaction is dropped, no R beat is issued, and the block restarts in IDLE.

Test Plan:
- Preload mem[0]=32'h0000_0413, RAND_EN=0, FIXED_LAT=1; AR 32'h8000_0000 → rvalid exactly 1 cycle after accept, rdata=32'h0000_0413, rresp=00.
- FIXED_LAT=5, rready held low 3 cycles after rvalid → rvalid/rdata stable throughout; accept-to-rvalid = 5 cycles; arready returns 1 cycle after the handshake.
- AR 32'h8000_0002 → rresp=10, rdata=0. AR 32'h8000_1000 with DEPTH_LOG2=10 → rresp=11. AR 32'h7FFF_FFFC → rresp=11.
- RAND_EN=1, SEED=211, 20 back-to-back reads of preloaded incrementing data → every rdata matches its address, each latency equals the reference-model LFSR[3:0]+1, and arready is never high while rvalid=1.
- Assert rst=0 asynchronously during WAIT → arready and rvalid drop to 0 immediately with no clock edge; after release no stale R beat is issued and arready=1 on the first edge.
- Same-cycle ld_en to the word being read: mem[4]=A, write B during the read cycle → rdata=A; the following read → B.
